// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer that shares one UART transmitter among NUM_REQ byte producers.
// Optional packet lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_done,
  input  logic                 tx_ready,
  output logic                 sent_valid,
  output logic [ID_W-1:0]      sent_id,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic [NUM_REQ-1:0] cand;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   next_ptr;
  logic [7:0]        win_byte;
  logic              launch_ok;

`ifdef UART_ARB_LOCK_EN
  logic            lock_q;
  logic [ID_W-1:0] lock_id_q;

  // A locked packet owner is the only candidate until its last byte is accepted.
  always_comb begin
    cand = req_valid;
    if (lock_q) begin
      cand            = '0;
      cand[lock_id_q] = req_valid[lock_id_q];
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  always_comb cand = req_valid;
`endif

  // First candidate at or above rr_ptr_q, wrapping at NUM_REQ-1.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = rr_ptr_q;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && cand[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    win_byte  = req_byte[{winner, 3'b000} +: 8];
    launch_ok = tx_ready && !tx_done && found;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      req_ack    <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      sent_valid <= 1'b0;
      sent_id    <= '0;
      busy       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      req_ack    <= '0;
      tx_dv      <= 1'b0;
      sent_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (launch_ok) begin
            tx_byte  <= win_byte;
            gnt_id_q <= winner;
            req_ack  <= NUM_REQ'(1) << winner;
            tx_dv    <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StLaunch;
`ifdef UART_ARB_LOCK_EN
            // Pointer moves only on the first grant of a packet.
            if (!lock_q) rr_ptr_q <= next_ptr;
            lock_q    <= !req_last[winner];
            lock_id_q <= winner;
`else
            rr_ptr_q <= next_ptr;
`endif
          end
        end
        StLaunch: begin
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (tx_done) begin
            sent_valid <= 1'b1;
            sent_id    <= gnt_id_q;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `UART_TX` transmitter among `NUM_REQ` byte producers. It sits between the requesters (CPU MMIO port, debug/trace sources) and the `UART_TX` `tx_dv`/`tx_byte`/`tx_done`/`tx_ready` handshake. It launches one byte at a time and waits for transmit completion before granting the next requester. It reports which requester's byte finished.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2; `ID_W` = `$clog2(NUM_REQ)` (localparam).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte pending.
- `req_byte`  in  8*NUM_REQ  byte of requester i at `[8*i +: 8]`.
- `req_last`  in  NUM_REQ  byte is last of a packet; used only with `UART_ARB_LOCK_EN`, ignored otherwise.
- `req_ack`  out  NUM_REQ  one-cycle one-hot pulse: byte of requester i accepted.
- `tx_dv`  out  1  launch strobe to `UART_TX`.
- `tx_byte`  out  8  byte to `UART_TX`, held stable from launch until `tx_done` is seen.
- `tx_done`  in  1  `UART_TX` completion; may be multi-cycle.
- `tx_ready`  in  1  `UART_TX` idle.
- `sent_valid`  out  1  one-cycle pulse: a byte finished transmitting.
- `sent_id`  out  ID_W  requester index of the finished byte; valid with `sent_valid`.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - Eligible when `tx_ready`=1, `tx_done`=0 and any `req_valid`=1.
  - Winner = first set `req_valid` bit scanning upward from `rr_ptr`, wrapping at NUM_REQ-1 → 0.
  - On the edge: latch `req_byte[winner]` into `tx_byte`; `gnt_id`=winner; `req_ack[winner]`=1; `rr_ptr`=winner+1 (wraps to 0); → LAUNCH.
- LAUNCH: `tx_dv`=1 for exactly this cycle; `req_ack` deasserts; → WAIT_DONE unconditionally.
- WAIT_DONE:
  - `tx_dv`=0; `req_valid` ignored.
  - On `tx_done`=1: `sent_valid`=1 and `sent_id`=`gnt_id` next cycle; → IDLE.
- Requester rules:
  - Hold `req_valid`/`req_byte` stable until `req_ack`; may change the cycle after `req_ack`.
  - No withdrawal before ack; behaviour is undefined if withdrawn.
- Only registered outputs; no combinational path from inputs to outputs.
- Reset values: all outputs 0, `tx_byte`=8'h00, `rr_ptr`=0, `gnt_id`=0, state IDLE.
  - Priority after reset is 0,1,2,…
- Reset mid-transfer: next edge returns to IDLE with outputs cleared. The `UART_TX` is not reset by this block, so the next launch waits for `tx_ready`=1, `tx_done`=0.

## Timing
- `req_valid` sampled in IDLE at cycle t → `req_ack` and `tx_dv` high during cycle t+1 → WAIT_DONE from t+2.
- `tx_done` sampled at cycle d → `sent_valid` high in d+1, state IDLE in d+1.
- Earliest next launch: decided in d+1 if `tx_done` already low, else the first cycle `tx_done`=0.
  - Minimum per-byte overhead: 3 cycles plus UART frame time.
- Simultaneous requests: exactly one ack per launch.
  - Every continuously valid requester is served within NUM_REQ launches.
- `tx_dv` never asserts while state is WAIT_DONE, or while `tx_ready`=0 at decision time.

## Configuration
- `UART_ARB_LOCK_EN` defined: packet lock.
  - When a granted byte has `req_last`=0, set `lock`=1, `lock_id`=winner.
  - While locked, IDLE considers only `req_valid[lock_id]`; other requesters wait even if valid.
  - Locked grants do not update `rr_ptr`, so the pointer advances only on the packet's first grant.
  - Lock clears when a byte from `lock_id` with `req_last`=1 is acked.
  - Reset clears `lock`.
- `UART_ARB_LOCK_EN` undefined: no lock state; `req_last` unused; pure per-byte round robin.

## Test plan
- Single request: after reset, `req_valid`=4'b0001, byte 8'hF4 → one `req_ack`=0001 pulse; `tx_dv` one cycle with `tx_byte`=F4; after `tx_done`, `sent_valid` with `sent_id`=0; `busy` drops.
- Round robin: all four valid, bytes 8'h10..8'h13 held valid → launch order ids 0,1,2,3,0; each `tx_byte` matches its id; never two acks in one launch.
- Back-pressure: `tx_ready`=0 with `req_valid`=0010 → no ack, no `tx_dv`; `tx_ready` rises at cycle t → `tx_dv` in t+1.
- Multi-cycle `tx_done` held 3 cycles → exactly one `sent_valid`; next launch only after `tx_done` low.
- Reset mid-transfer: `rst_n`=0 for one cycle during WAIT_DONE → all outputs 0 next cycle; following request to id 2 with byte 8'h12 launches normally, priority order restarts at id 0.
- `UART_ARB_LOCK_EN`: id 1 sends 8'hA0/A1/A2 with `req_last`=0,0,1 while id 0 is valid → sequence A0,A1,A2, then id 0's byte; without the macro, bytes interleave 1,0,1,…
